// File: rtl/pcm_sample_fifo.sv
// Single-clock PCM sample FIFO with fill level, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and an optional first-word-fall-through read port.
module pcm_sample_fifo #(
  parameter int DBITS    = 16,
  parameter int ABITS    = 10,
  parameter int AF_LEVEL = (1 << ABITS) - 4,
  parameter int AE_LEVEL = 4,
  parameter int FWFT     = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr,
  input  logic [DBITS-1:0] din,
  input  logic             rd,
  output logic [DBITS-1:0] dout,
  output logic             dout_valid,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [ABITS:0]   level,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam int DEPTH = 1 << ABITS;
  localparam logic [ABITS:0]   DEPTH_C    = DEPTH[ABITS:0];
  localparam logic [ABITS:0]   AF_C       = AF_LEVEL[ABITS:0];
  localparam logic [ABITS:0]   AE_C       = AE_LEVEL[ABITS:0];
  localparam logic [ABITS:0]   LVL_ZERO_C = {(ABITS+1){1'b0}};
  localparam logic [ABITS:0]   LVL_ONE_C  = {{ABITS{1'b0}}, 1'b1};
  localparam logic [ABITS-1:0] PTR_ZERO_C = {ABITS{1'b0}};
  localparam logic [ABITS-1:0] PTR_ONE_C  = {{(ABITS-1){1'b0}}, 1'b1};

  logic [DBITS-1:0] mem_r [DEPTH];
  logic [ABITS-1:0] wr_ptr_r;
  logic [ABITS-1:0] rd_ptr_r;
  logic [ABITS:0]   level_r;
  logic [ABITS:0]   level_nxt_s;
  logic             empty_r;
  logic             full_r;
  logic             almost_empty_r;
  logic             almost_full_r;
  logic             overflow_r;
  logic             underflow_r;
  logic             wr_acc_s;
  logic             rd_acc_s;
  logic             ov_evt_s;
  logic             uf_evt_s;

  // Acceptance against the registered flags and the resulting next occupancy
  always_comb begin
    wr_acc_s    = wr & ~full_r;
    rd_acc_s    = rd & ~empty_r;
    ov_evt_s    = wr & full_r;
    uf_evt_s    = rd & empty_r;
    level_nxt_s = level_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   level_nxt_s = level_r + LVL_ONE_C;
      2'b01:   level_nxt_s = level_r - LVL_ONE_C;
      default: level_nxt_s = level_r;
    endcase
  end

  // Pointers, level and status flags; flags follow next-level so they move with level
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r       <= PTR_ZERO_C;
      rd_ptr_r       <= PTR_ZERO_C;
      level_r        <= LVL_ZERO_C;
      empty_r        <= 1'b1;
      full_r         <= 1'b0;
      almost_empty_r <= 1'b1;
      almost_full_r  <= 1'b0;
      overflow_r     <= 1'b0;
      underflow_r    <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      level_r        <= level_nxt_s;
      empty_r        <= (level_nxt_s == LVL_ZERO_C);
      full_r         <= (level_nxt_s == DEPTH_C);
      almost_empty_r <= (level_nxt_s <= AE_C);
      almost_full_r  <= (level_nxt_s >= AF_C);
      // A fresh error event outranks a coincident clear
      overflow_r     <= ov_evt_s | (overflow_r & ~clr_err);
      underflow_r    <= uf_evt_s | (underflow_r & ~clr_err);
    end
  end

  // Sample storage; deliberately not reset
  always_ff @(posedge clock) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented combinationally; rd acknowledges it
      assign dout       = mem_r[rd_ptr_r];
      assign dout_valid = ~empty_r;
    end else begin : g_std
      logic [DBITS-1:0] dout_r;
      logic             dout_valid_r;

      // Registered read port: one-cycle valid pulse per accepted pop
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          dout_r       <= {DBITS{1'b0}};
          dout_valid_r <= 1'b0;
        end else begin
          if (rd_acc_s) begin
            dout_r <= mem_r[rd_ptr_r];
          end
          dout_valid_r <= rd_acc_s;
        end
      end

      assign dout       = dout_r;
      assign dout_valid = dout_valid_r;
    end
  endgenerate

  assign empty        = empty_r;
  assign full         = full_r;
  assign almost_empty = almost_empty_r;
  assign almost_full  = almost_full_r;
  assign level        = level_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule

// File: tb/tb_pcm_sample_fifo.sv
// Bench for pcm_sample_fifo: a standard-read and an FWFT instance share stimulus and are
// checked against a queue-based model of the FIFO.
module tb_pcm_sample_fifo;

  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic        clr_err = 1'b0;
  logic [15:0] din = 16'h0000;

  logic [15:0] dout0, dout1;
  logic        dv0, dv1, empty0, empty1, full0, full1, ae0, ae1, af0, af1, ov0, ov1, uf0, uf1;
  logic [4:0]  level0, level1;
  logic [10:0] stat0, stat1;

  assign stat0 = {full0, empty0, ae0, af0, ov0, uf0, level0};
  assign stat1 = {full1, empty1, ae1, af1, ov1, uf1, level1};

  pcm_sample_fifo #(.DBITS(16), .ABITS(4), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dut_std (
    .clock(clock), .reset(reset), .wr(wr), .din(din), .rd(rd),
    .dout(dout0), .dout_valid(dv0), .empty(empty0), .full(full0),
    .almost_empty(ae0), .almost_full(af0), .level(level0),
    .overflow(ov0), .underflow(uf0), .clr_err(clr_err));

  pcm_sample_fifo #(.DBITS(16), .ABITS(4), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dut_fwft (
    .clock(clock), .reset(reset), .wr(wr), .din(din), .rd(rd),
    .dout(dout1), .dout_valid(dv1), .empty(empty1), .full(full1),
    .almost_empty(ae1), .almost_full(af1), .level(level1),
    .overflow(ov1), .underflow(uf1), .clr_err(clr_err));

  always #5 clock = ~clock;

  // Reference model
  logic [15:0] q[$];
  logic        m_ov, m_uf, m_dv0;
  logic [15:0] m_dout0;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [10:0] exp_stat();
    int n;
    logic [4:0] l;
    n = q.size();
    l = n[4:0];
    return {(n == DEPTH), (n == 0), (n <= AE), (n >= AF), m_ov, m_uf, l};
  endfunction

  task automatic model_clear();
    q.delete();
    m_ov = 1'b0; m_uf = 1'b0; m_dv0 = 1'b0; m_dout0 = 16'h0000;
  endtask

  // One clock of stimulus; the model follows the acceptance rules at the edge
  task automatic cycle(input logic w, input logic [15:0] d, input logic r, input logic c);
    bit was_full, was_empty, wa, ra;
    wr = w; din = d; rd = r; clr_err = c;
    @(posedge clock);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    wa = w && !was_full;
    ra = r && !was_empty;
    m_dv0 = ra;
    if (ra) m_dout0 = q.pop_front();
    if (wa) q.push_back(d);
    m_ov = (w && was_full) ? 1'b1 : (c ? 1'b0 : m_ov);
    m_uf = (r && was_empty) ? 1'b1 : (c ? 1'b0 : m_uf);
    #1;
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (stat0 !== 11'b01100000000) begin
        n_err++; $display("FAIL reset_stat_std got=%b exp=%b", stat0, 11'b01100000000);
      end
      n_vec++;
      if (stat1 !== 11'b01100000000) begin
        n_err++; $display("FAIL reset_stat_fwft got=%b exp=%b", stat1, 11'b01100000000);
      end
      n_vec++;
      if ({dv0, dv1, dout0} !== 18'h00000) begin
        n_err++; $display("FAIL reset_dout got dv0=%b dv1=%b dout0=%h exp 0 0 0000", dv0, dv1, dout0);
      end
      cycle(1'b0, 16'h0000, 1'b0, 1'b0);
    end
  endtask

  task automatic test_fill();
    logic [15:0] v;
    for (int i = 1; i <= 17; i++) begin
      v = (i == 17) ? 16'hDEAD : 16'(i);
      cycle(1'b1, v, 1'b0, 1'b0);
      n_vec++;
      if (stat0 !== exp_stat() || stat1 !== exp_stat()) begin
        n_err++; $display("FAIL fill_stat wr#%0d got=%b/%b exp=%b", i, stat0, stat1, exp_stat());
      end
      n_vec++;
      if (af0 !== (i >= 12) || full0 !== (i >= 16)) begin
        n_err++; $display("FAIL fill_thresh wr#%0d got af=%b full=%b exp af=%b full=%b",
                          i, af0, full0, (i >= 12), (i >= 16));
      end
      n_vec++;
      if (dv1 !== 1'b1 || dout1 !== 16'h0001) begin
        n_err++; $display("FAIL fill_fwft_head wr#%0d got %b/%h exp 1/0001", i, dv1, dout1);
      end
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 16'h0000, 1'b1, 1'b0);
      n_vec++;
      if (dv0 !== 1'b1 || dout0 !== 16'(i) || dout0 !== m_dout0) begin
        n_err++; $display("FAIL drain_dout rd#%0d got %b/%h exp 1/%h", i, dv0, dout0, 16'(i));
      end
      n_vec++;
      if (stat0 !== exp_stat() || stat1 !== exp_stat()) begin
        n_err++; $display("FAIL drain_stat rd#%0d got=%b/%b exp=%b", i, stat0, stat1, exp_stat());
      end
      cycle(1'b0, 16'h0000, 1'b0, 1'b0);
      n_vec++;
      if (dv0 !== 1'b0 || dout0 !== 16'(i)) begin
        n_err++; $display("FAIL drain_pulse rd#%0d got %b/%h exp 0/%h", i, dv0, dout0, 16'(i));
      end
      n_vec++;
      if (q.size() != 0 && (dv1 !== 1'b1 || dout1 !== q[0])) begin
        n_err++; $display("FAIL drain_fwft rd#%0d got %b/%h exp 1/%h", i, dv1, dout1, q[0]);
      end
    end
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    n_vec++;
    if (stat0 !== exp_stat() || uf0 !== 1'b1 || ov0 !== 1'b1 || dv0 !== 1'b0) begin
      n_err++; $display("FAIL extra_rd got stat=%b dv=%b exp stat=%b dv=0", stat0, dv0, exp_stat());
    end
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);
    n_vec++;
    if (stat0 !== 11'b01100000000 || stat1 !== 11'b01100000000) begin
      n_err++; $display("FAIL clr_err got=%b/%b exp=%b", stat0, stat1, 11'b01100000000);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 16'($urandom), 1'b1, 1'b0);
      n_vec++;
      if (level0 !== 5'd3 || level1 !== 5'd3 || stat0 !== exp_stat()) begin
        n_err++; $display("FAIL b2b_level cyc=%0d got=%0d/%0d exp=3", i, level0, level1);
      end
      n_vec++;
      if (dv0 !== 1'b1 || dout0 !== m_dout0 || dout1 !== q[0]) begin
        n_err++; $display("FAIL b2b_order cyc=%0d got %h/%h exp %h/%h", i, dout0, dout1, m_dout0, q[0]);
      end
    end
  endtask

  task automatic test_collide();
    logic [15:0] v;
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 16'hBEEF, 1'b1, 1'b0);
    n_vec++;
    if (level0 !== 5'd15 || ov0 !== 1'b1 || stat0 !== exp_stat() || stat1 !== exp_stat()) begin
      n_err++; $display("FAIL collide_full got level=%0d ov=%b exp level=15 ov=1", level0, ov0);
    end
    while (q.size() != 0) cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    n_vec++;
    if (dout0 === 16'hBEEF) begin
      n_err++; $display("FAIL collide_dropped got=%h exp=not BEEF", dout0);
    end
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);
    v = 16'($urandom);
    cycle(1'b1, v, 1'b1, 1'b0);
    n_vec++;
    if (level0 !== 5'd1 || uf0 !== 1'b1 || ov0 !== 1'b0 || stat1 !== exp_stat() || dv0 !== 1'b0) begin
      n_err++; $display("FAIL collide_empty got level=%0d uf=%b ov=%b dv=%b exp 1 1 0 0", level0, uf0, ov0, dv0);
    end
    n_vec++;
    if (dout1 !== v || dv1 !== 1'b1) begin
      n_err++; $display("FAIL collide_empty_data got %b/%h exp 1/%h", dv1, dout1, v);
    end
  endtask

  task automatic test_random();
    logic w, r, c;
    int pw;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      pw = ((i % 100) < 50) ? 75 : 25;
      w = ($urandom_range(0, 99) < pw);
      r = ($urandom_range(0, 99) < (100 - pw));
      c = ($urandom_range(0, 19) == 0);
      cycle(w, 16'($urandom), r, c);
      n_vec++;
      if (stat0 !== exp_stat() || stat1 !== exp_stat()) begin
        n_err++; $display("FAIL rand_stat cyc=%0d got=%b/%b exp=%b", i, stat0, stat1, exp_stat());
      end
      n_vec++;
      if (dv0 !== m_dv0 || dout0 !== m_dout0) begin
        n_err++; $display("FAIL rand_std cyc=%0d got %b/%h exp %b/%h", i, dv0, dout0, m_dv0, m_dout0);
      end
      n_vec++;
      if (dv1 !== (q.size() != 0) || (q.size() != 0 && dout1 !== q[0])) begin
        n_err++; $display("FAIL rand_fwft cyc=%0d got %b/%h exp valid=%b", i, dv1, dout1, (q.size() != 0));
      end
    end
  endtask

  task automatic test_fwft();
    do_reset();
    cycle(1'b1, 16'hABCD, 1'b0, 1'b0);
    n_vec++;
    if (dv1 !== 1'b1 || dout1 !== 16'hABCD) begin
      n_err++; $display("FAIL fwft_present got %b/%h exp 1/abcd", dv1, dout1);
    end
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    n_vec++;
    if (dv1 !== 1'b0 || empty1 !== 1'b1) begin
      n_err++; $display("FAIL fwft_pop got dv=%b empty=%b exp 0 1", dv1, empty1);
    end
    for (int i = 0; i < 7; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
    n_vec++;
    if (level1 !== 5'd7 || level0 !== 5'd7) begin
      n_err++; $display("FAIL fwft_level7 got=%0d/%0d exp=7", level0, level1);
    end
    #2 reset = 1'b1;
    #1;
    model_clear();
    n_vec++;
    if (stat0 !== 11'b01100000000 || stat1 !== 11'b01100000000 || dv1 !== 1'b0) begin
      n_err++; $display("FAIL async_reset got=%b/%b exp=%b", stat0, stat1, 11'b01100000000);
    end
    @(negedge clock);
    reset = 1'b0;
    cycle(1'b1, 16'h1234, 1'b0, 1'b0);
    n_vec++;
    if (dout1 !== 16'h1234 || level1 !== 5'd1) begin
      n_err++; $display("FAIL post_reset_write got %h/%0d exp 1234/1", dout1, level1);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_collide();
    test_random();
    test_fwft();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
